// File: rtl/alu_acc_pkg.sv
// Shared encodings for the accumulator ALU controller: opcodes, result selects,
// controller states and the queued command word.
package alu_acc_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SEL_COMPUTE  = 2'b00,
    SEL_PASS_ACC = 2'b01,
    SEL_PASS_B   = 2'b10,
    SEL_LOAD     = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_e;

  typedef struct packed {
    op_e               op;
    sel_e              sel;
    logic [DATA_W-1:0] data;
    logic              cin;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command queue with full/empty flags; pointers wrap modulo DEPTH
// and an explicit occupancy count distinguishes full from empty.
module alu_cmd_fifo
  import alu_acc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator ALU controller: queues commands, issues one per cycle into a
// held result register, and chains each result into the accumulator.
module alu_acc_ctrl
  import alu_acc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_cin,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cout,
  output logic [DATA_W-1:0] acc
);

  cmd_t            cmd_in;
  cmd_t            head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            issue;
  logic            ready_en;
  logic [DATA_W:0] alu_out;
  state_e          state;

  function automatic logic [DATA_W:0] alu_eval(cmd_t c, logic [DATA_W-1:0] a);
    logic [DATA_W:0] ext_a;
    logic [DATA_W:0] ext_b;
    logic [DATA_W:0] r;
    ext_a = {1'b0, a};
    ext_b = {1'b0, c.data};
    r     = '0;
    case (c.sel)
      SEL_PASS_ACC: r = ext_a;
      SEL_PASS_B:   r = ext_b;
      SEL_LOAD:     r = ext_b;
      default: begin
        case (c.op)
          OP_AND:  r = ext_a & ext_b;
          OP_ADD:  r = ext_a + ext_b + {{DATA_W{1'b0}}, c.cin};
          // Bit DATA_W of the 5-bit difference is the borrow.
          OP_SUB:  r = ext_a - ext_b;
          default: r = {{DATA_W{1'b0}}, ^c.data};
        endcase
      end
    endcase
    return r;
  endfunction

  assign cmd_in    = '{op: op_e'(cmd_op), sel: sel_e'(cmd_sel), data: cmd_data, cin: cmd_cin};
  assign cmd_ready = ready_en && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign res_valid = (state != ST_IDLE);
  assign issue     = !fifo_empty && (!res_valid || res_ready);
  assign alu_out   = alu_eval(head, acc);

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (cmd_in),
    .pop   (issue),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue stage: result register and accumulator load on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc      <= '0;
      res_data <= '0;
      res_cout <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (issue) begin
        state    <= ST_RUN;
        res_data <= alu_out[DATA_W-1:0];
        res_cout <= alu_out[DATA_W];
        if (head.sel != SEL_PASS_ACC) acc <= alu_out[DATA_W-1:0];
      end else if (res_ready) begin
        state <= ST_IDLE;
      end else if (res_valid) begin
        state <= ST_STALL;
      end
    end
  end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed bench for alu_acc_ctrl with an arithmetic reference model and a
// per-cycle output monitor.
module tb_alu_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [1:0] cmd_sel = 2'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       cmd_cin = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_cout;
  logic [3:0] acc;

  int n_vec = 0;
  int n_fail = 0;
  int res_count = 0;

  typedef struct {int res; int cout; int acc;} exp_t;
  typedef struct {int op; int sel; int data; int cin; int res; int cout; int acc;} vec_t;

  exp_t exp_q[$];
  int   m_acc = 0;

  always #5 clk = ~clk;

  alu_acc_ctrl #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_sel   (cmd_sel),
    .cmd_data  (cmd_data),
    .cmd_cin   (cmd_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cout  (res_cout),
    .acc       (acc)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic exp_t model(input int op, input int sel, input int b, input int cin, input int a);
    int r;
    exp_t e;
    case (sel)
      1:       r = a;
      2, 3:    r = b;
      default: begin
        case (op)
          0:       r = a & b;
          1:       r = a + b + cin;
          2:       r = a - b;
          default: r = $countones(b) % 2;
        endcase
      end
    endcase
    e.res  = r & 15;
    e.cout = (r < 0 || r > 15) ? 1 : 0;
    e.acc  = (sel == 1) ? a : e.res;
    return e;
  endfunction

  // Monitor: model fed by accepted commands, checked on every visible result.
  logic       held = 1'b0;
  logic [3:0] held_data;
  logic       held_cout;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_acc = 0;
        held  = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", int'(res_valid), 1);
          chk("hold_data", int'(res_data), int'(held_data));
          chk("hold_cout", int'(res_cout), int'(held_cout));
        end
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_result", int'(res_valid), 0);
          end else begin
            chk("mon_res", int'(res_data), exp_q[0].res);
            chk("mon_cout", int'(res_cout), exp_q[0].cout);
            chk("mon_acc", int'(acc), exp_q[0].acc);
            if (res_ready) begin
              void'(exp_q.pop_front());
              res_count++;
            end
          end
        end
        held      = res_valid && !res_ready;
        held_data = res_data;
        held_cout = res_cout;
        if (cmd_valid && cmd_ready) begin
          e = model(int'(cmd_op), int'(cmd_sel), int'(cmd_data), int'(cmd_cin), m_acc);
          m_acc = e.acc;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic send(input int op, input int sel, input int data, input int cin);
    int n = 0;
    cmd_op    = 2'(op);
    cmd_sel   = 2'(sel);
    cmd_data  = 4'(data);
    cmd_cin   = 1'(cin);
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        timeout("send_accept");
        cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_lit(input string name, input int res, input int cout, input int accv);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!res_valid && k < 10);
    if (!res_valid) begin
      timeout(name);
    end else begin
      chk({name, "_latency"}, k, 2);
      chk({name, "_res"}, int'(res_data), res);
      chk({name, "_cout"}, int'(res_cout), cout);
      chk({name, "_acc"}, int'(acc), accv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dv[$];
    int   base;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_cout", int'(res_cout), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", int'(cmd_ready), 1);
    chk("post_rst_res_valid", int'(res_valid), 0);

    // Directed single commands with hand-computed results
    res_ready = 1'b1;
    dv.push_back('{0, 3,  9, 0,  9, 0,  9});
    dv.push_back('{1, 0,  8, 1,  2, 1,  2});
    dv.push_back('{0, 3,  3, 0,  3, 0,  3});
    dv.push_back('{2, 0,  5, 0, 14, 1, 14});
    dv.push_back('{0, 3,  7, 0,  7, 0,  7});
    dv.push_back('{2, 0,  3, 1,  4, 0,  4});
    dv.push_back('{3, 0, 11, 0,  1, 0,  1});
    dv.push_back('{0, 3,  6, 0,  6, 0,  6});
    dv.push_back('{1, 1,  9, 1,  6, 0,  6});
    dv.push_back('{0, 0, 10, 0,  2, 0,  2});
    dv.push_back('{2, 2,  5, 1,  5, 0,  5});
    dv.push_back('{1, 0, 15, 1,  5, 1,  5});
    dv.push_back('{3, 0,  7, 1,  1, 0,  1});
    dv.push_back('{3, 0,  6, 0,  0, 0,  0});
    foreach (dv[i]) begin
      send(dv[i].op, dv[i].sel, dv[i].data, dv[i].cin);
      expect_lit($sformatf("dir%0d", i), dv[i].res, dv[i].cout, dv[i].acc);
    end

    // Back-pressure: four commands offered while results are held
    base      = res_count;
    res_ready = 1'b0;
    fork
      begin
        send(0, 3, 5, 0);
        send(1, 0, 3, 0);
        send(2, 0, 1, 0);
        send(3, 0, 7, 0);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_cmd_ready", int'(cmd_ready), 0);
        chk("bp_res_valid", int'(res_valid), 1);
        chk("bp_res_data", int'(res_data), 5);
        chk("bp_acc", int'(acc), 5);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", res_count - base, 4);
    chk("bp_final_acc", int'(acc), 1);

    // Sustained streaming: one command and one result per cycle
    base = res_count;
    for (int i = 0; i < 16; i++) begin
      cmd_op    = 2'(i % 4);
      cmd_sel   = (i % 5 == 4) ? 2'd1 : ((i % 7 == 3) ? 2'd3 : 2'd0);
      cmd_data  = 4'((i * 5 + 3) % 16);
      cmd_cin   = 1'(i % 2);
      cmd_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("tp_cmd_ready%0d", i), int'(cmd_ready), 1);
      if (i >= 2) chk($sformatf("tp_res_valid%0d", i), int'(res_valid), 1);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("tp_tail_valid", int'(res_valid), 1);
    end
    @(negedge clk);
    chk("tp_idle_after", int'(res_valid), 0);
    chk("tp_count", res_count - base, 16);
    @(posedge clk);
    #1;

    // Reset with a full queue and a pending result
    res_ready = 1'b0;
    send(0, 3, 12, 0);
    send(1, 0, 1, 0);
    send(1, 0, 2, 0);
    chk("pre_rst_cmd_ready", int'(cmd_ready), 0);
    chk("pre_rst_res_valid", int'(res_valid), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_res_data", int'(res_data), 0);
    chk("mid_rst_res_cout", int'(res_cout), 0);
    chk("mid_rst_acc", int'(acc), 0);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_cmd_ready", int'(cmd_ready), 1);
    res_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rel_no_stale", int'(res_valid), 0);
    end
    @(posedge clk);
    #1;
    send(1, 0, 5, 0);
    expect_lit("after_rst", 5, 0, 5);
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
